// File: rtl/if_id_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buf_pkg
// Brief    : Shared widths, constants and occupancy encoding for the IF/ID
//            instruction buffer.
// Revision : 1.0 - initial release
// ============================================================================
package if_id_buf_pkg;

    localparam int c_INST_ADDR_W = 32;
    localparam int c_INST_W      = 32;
    localparam int c_IFBUF_DEPTH = 4;
    localparam int c_IFBUF_PTR_W = $clog2(c_IFBUF_DEPTH);

    localparam logic [c_INST_W-1:0] c_ZERO_WORD = 32'h0000_0000;

    // Occupancy is decoded from the pointers; there is no state register.
    typedef logic [1:0] occ_t;
    localparam occ_t c_OCC_EMPTY   = 2'd0;
    localparam occ_t c_OCC_PARTIAL = 2'd1;
    localparam occ_t c_OCC_FULL    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_id_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buf_if
// Brief    : Fetch/decode handshake bundle around the IF/ID buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_buf_if #(
    parameter int PTR_W = 2
);
    logic [31:0]  if_pc;
    logic [31:0]  if_inst;
    logic         if_valid;
    logic         if_ready;
    logic [31:0]  id_pc;
    logic [31:0]  id_inst;
    logic         id_valid;
    logic         id_ready;
    logic         flush;
    logic [PTR_W:0] count;

    modport master (
        output if_pc, if_inst, if_valid, id_ready, flush,
        input  if_ready, id_pc, id_inst, id_valid, count
    );

    modport slave (
        input  if_pc, if_inst, if_valid, id_ready, flush,
        output if_ready, id_pc, id_inst, id_valid, count
    );
endinterface
`default_nettype wire

// File: rtl/if_id_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buf_fifo
// Brief    : Show-ahead synchronous FIFO with wrap-bit pointers.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic      [PTR_W:0]   count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is never cleared; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[PTR_W-1:0]] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign count = r_wr_ptr - r_rd_ptr;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/if_id_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buf
// Brief    : IF/ID instruction buffer with flush, NOP bubble and back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH = c_IFBUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    if_id_buf_if.slave   bus
);

    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic [63:0] w_rdata;
    logic [PTR_W:0] w_count;
    occ_t        w_occ;

    always_comb begin
        w_occ = c_OCC_EMPTY;
        if (w_full)        w_occ = c_OCC_FULL;
        else if (!w_empty) w_occ = c_OCC_PARTIAL;
    end

    // Ready depends only on registered occupancy, never on id_ready.
    assign bus.if_ready = (w_occ != c_OCC_FULL);
    assign bus.id_valid = (w_occ != c_OCC_EMPTY);

    assign w_push = bus.if_valid && bus.if_ready && !bus.flush;
    assign w_pop  = bus.id_valid && bus.id_ready && !bus.flush;

    if_id_buf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({bus.if_pc, bus.if_inst}),
        .rdata (w_rdata),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    assign bus.id_pc   = bus.id_valid ? w_rdata[63:32] : 32'h0;
    assign bus.id_inst = bus.id_valid ? w_rdata[31:0]  : c_ZERO_WORD;
    assign bus.count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_buf
// Brief    : Directed self-checking bench for the IF/ID instruction buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buf;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    if_id_buf_if #(.PTR_W(2)) bus ();

    if_id_buf u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst_of(pc);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"},    32'(bus.count), 32'd0);
        chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd1 - 32'd1);
        chk({tag, "_id_inst"},  bus.id_inst, 32'h0);
        chk({tag, "_id_pc"},    bus.id_pc, 32'h0);
        chk({tag, "_if_ready"}, 32'(bus.if_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] q[$];
        int          pushed;
        int          popped;
        int          cyc;
        logic        pop_now;
        logic        push_now;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        drive(1'b0, 32'h0);

        // Reset for two cycles
        tick; tick;
        chk_empty("reset");
        rst = 1'b0;

        // Streaming with decode always ready
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i));
            tick;
            chk($sformatf("stream_pc%0d", i), bus.id_pc, 32'(4 * i));
            chk($sformatf("stream_inst%0d", i), bus.id_inst, inst_of(32'(4 * i)));
            chk($sformatf("stream_cnt%0d", i), 32'(bus.count), 32'd1);
        end
        drive(1'b0, 32'h0);
        tick;
        chk_empty("stream_end");

        // Fill with decode stalled; fifth push must be refused
        bus.id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i));
            chk($sformatf("fill_rdy%0d", i), 32'(bus.if_ready), (i < 4) ? 32'd1 : 32'd0);
            tick;
        end
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_head", bus.id_pc, 32'h0);

        // Pop while full: push in the same cycle is still refused
        drive(1'b1, 32'h99);
        bus.id_ready = 1'b1;
        tick;
        chk("fullpop_count", 32'(bus.count), 32'd3);
        chk("fullpop_head", bus.id_pc, 32'h4);
        drive(1'b0, 32'h0);
        tick;
        chk("drain_pc8", bus.id_pc, 32'h8);
        tick;
        chk("drain_pcC", bus.id_pc, 32'hC);
        tick;
        chk_empty("drain_end");

        // Flush at count 3 with a concurrent push
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i));
            tick;
        end
        chk("preflush_count", 32'(bus.count), 32'd3);
        drive(1'b1, 32'h10C);
        bus.flush = 1'b1;
        chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
        tick;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0);
        chk_empty("flush");

        // Push into empty with pop asserted: no pop, entry visible next cycle
        bus.id_ready = 1'b1;
        drive(1'b1, 32'h200);
        chk("emptypush_valid_before", 32'(bus.id_valid), 32'd0);
        tick;
        drive(1'b0, 32'h0);
        chk("emptypush_pc", bus.id_pc, 32'h200);
        chk("emptypush_count", 32'(bus.count), 32'd1);
        tick;
        chk("emptypush_drained", 32'(bus.count), 32'd0);

        // Wrap-around: 12 pushes with random decode stalls
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while (popped < 12 && cyc < 300) begin
            bus.id_ready = 1'($urandom_range(0, 1));
            drive(pushed < 12, 32'h300 + 32'(4 * pushed));
            chk("wrap_count", 32'(bus.count), 32'(q.size()));
            chk("wrap_if_ready", 32'(bus.if_ready), (q.size() < 4) ? 32'd1 : 32'd0);
            push_now = (pushed < 12) && (q.size() < 4);
            pop_now  = (q.size() != 0) && bus.id_ready;
            if (pop_now) chk("wrap_pc", bus.id_pc, q[0]);
            tick;
            if (pop_now) begin
                void'(q.pop_front());
                popped++;
            end
            if (push_now) begin
                q.push_back(32'h300 + 32'(4 * pushed));
                pushed++;
            end
            cyc++;
        end
        chk("wrap_all_popped", 32'(popped), 32'd12);
        drive(1'b0, 32'h0);
        bus.id_ready = 1'b0;

        // Reset mid-stream at count 2
        drive(1'b1, 32'h400);
        tick;
        drive(1'b1, 32'h404);
        tick;
        chk("prerst_count", 32'(bus.count), 32'd2);
        drive(1'b0, 32'h0);
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk_empty("midrst");
        drive(1'b1, 32'h500);
        tick;
        drive(1'b0, 32'h0);
        chk("postrst_pc", bus.id_pc, 32'h500);
        chk("postrst_count", 32'(bus.count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
